fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin, burst-locking arbiter that lets P_NUM_REQ write-domain requesters share one write port of a dual_clock_fifo.
- Sits entirely in the FIFO write clock domain. Drives the FIFO write-increment and write-data inputs, and is back-pressured by the FIFO full flag.
- Each written word carries the source ID so the read side can demultiplex.

Parameters:
- P_NUM_REQ, 4, number of requesters (2..16).
- P_DATA_MSB, 7, requester payload width minus 1.
- P_MAX_BURST, 16, maximum beats per grant before forced release (1..255).
- Derived constants:
  - L_ID_W = max($clog2(P_NUM_REQ),1).
  - L_CNT_W = $clog2(P_MAX_BURST+1).
  - FIFO word width = L_ID_W + P_DATA_MSB + 1.

Ports:
- i_clk  in  1  FIFO write clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  P_NUM_REQ  per-requester beat valid.
- i_req_last  in  P_NUM_REQ  per-requester end-of-packet marker, qualified by valid.
- i_req_data  in  P_NUM_REQ*(P_DATA_MSB+1)  packed payloads; requester k occupies slice k.
- o_req_ready  out  P_NUM_REQ  per-requester beat accepted this cycle.
- i_fifo_full  in  1  FIFO full flag, from the FIFO write-side full output.
- o_fifo_inc  out  1  FIFO write strobe, to the FIFO write-increment input.
- o_fifo_data  out  L_ID_W+P_DATA_MSB+1  {grant_id, payload}, to the FIFO write-data input.
- o_grant_id  out  L_ID_W  currently locked requester.
- o_busy  out  1  1 when the FSM is in LOCK.

Behaviour:
- Reset (async assert, sync deassert external):
  - state=IDLE, grant_id=0, rr_last=P_NUM_REQ-1, beat_cnt=0.
  - o_req_ready=0, o_fifo_inc=0, o_busy=0.
  - Outputs clear immediately on assertion.
- FSM states: IDLE, LOCK.
- IDLE:
  - If any i_req_valid: pick the first valid requester searching from rr_last+1 upward, with wrap modulo P_NUM_REQ.
  - Register the pick into grant_id, clear beat_cnt, go to LOCK.
  - Arbitration costs exactly 1 cycle; no beat transfers in IDLE.
  - No valid: stay in IDLE.
- LOCK:
  - o_req_ready[grant_id] = !i_fifo_full. All other ready bits are 0.
  - Beat transfers when i_req_valid[grant_id] & o_req_ready[grant_id].
  - On a transfer, o_fifo_inc=1 in the same cycle and o_fifo_data={grant_id, slice grant_id}. The path is combinational; no added latency.
  - o_fifo_inc=0 whenever no transfer occurs, so the FIFO never sees a write while full.
  - Every transfer increments beat_cnt.
  - Release to IDLE and set rr_last=grant_id when a transfer has i_req_last[grant_id]=1, or beat_cnt reaches P_MAX_BURST (forced release).
  - Granted requester drops valid: stay locked (packet semantics); the grant is held until last or the cap.
- Forced release mid-packet:
  - The requester must re-arbitrate.
  - Its remaining beats follow later, tagged with the same ID.
- Back-to-back grants: minimum 1 idle cycle between bursts (IDLE re-arbitration).
- Single requester continuously valid: it is re-granted after every release.
- i_fifo_full mid-burst: ready drops the same cycle, the lock is held, and beat_cnt does not advance.
- Requester IDs out of range (non-power-of-two P_NUM_REQ): never selected; the search skips them.

Decomposition:
- Package fifo_arb_pkg:
  - FSM state encoding (IDLE=0, LOCK=1).
  - ID-width and count-width helper functions.
  - Default constants.
- Sub-module rr_pick (combinational):
  - Inputs: request vector and rr_last.
  - Outputs: any_valid and pick_id.
  - Implements the rotate, priority-encode, un-rotate operation.
- Top-level holds the FSM, beat counter, output muxing, and ready decode.

Test Plan:
1. Reset, then all valid: o_req_ready=0, o_fifo_inc=0, o_busy=0. Release reset with req0 valid: grant_id=0 after 1 cycle, then first write.
2. Requesters 0..3 all valid, each sending a 2-beat packet with last on beat 2: grant order 0,1,2,3. Eight FIFO writes tagged IDs 0,0,1,1,2,2,3,3. One idle cycle between packets.
3. req2 sends 20 beats with no last, P_MAX_BURST=16: release after 16 writes. req1 valid meanwhile: req1 is granted next, then req2 resumes with 4 beats tagged ID 2.
4. i_fifo_full=1 for 5 cycles mid-burst: o_fifo_inc=0 and ready=0 for those cycles; beat_cnt is frozen; resumes on the same grant with no lost or duplicated beat.
5. Granted requester drops valid for 3 cycles mid-packet: o_busy stays 1; other valid requesters are not served until its last beat.
6. Assert i_rst_n low mid-burst (beat 3): outputs are 0 immediately. After release, arbitration restarts from ID 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types, width helpers and default constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_MSB  = 7;
  localparam int DEF_MAX_BURST = 16;

  function automatic int id_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_rr_last, wrapping.
// Rotates the request vector, priority-encodes the lowest set bit, then un-rotates.
module rr_pick #(
  parameter int P_N    = 4,
  parameter int P_ID_W = 2
) (
  input  logic [P_N-1:0]    i_req,
  input  logic [P_ID_W-1:0] i_rr_last,
  output logic              o_any_valid,
  output logic [P_ID_W-1:0] o_pick_id
);

  logic [2*P_N-1:0] dbl;
  logic [P_N-1:0]   rot;
  int               start_idx;
  int               pos;

  always_comb begin
    start_idx   = (int'(i_rr_last) + 1) % P_N;
    dbl         = {i_req, i_req};
    rot         = dbl[start_idx +: P_N];
    pos         = 0;
    o_any_valid = |i_req;
    // Descending scan so the lowest rotated position wins.
    for (int i = P_N - 1; i >= 0; i--) begin
      if (rot[i]) pos = i;
    end
    o_pick_id = P_ID_W'((start_idx + pos) % P_N);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locking round-robin arbiter sharing one FIFO write port among P_NUM_REQ requesters.
// One idle arbitration cycle per grant; beats pass combinationally and stall while the FIFO is full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  P_NUM_REQ   = DEF_NUM_REQ,
  parameter int  P_DATA_MSB  = DEF_DATA_MSB,
  parameter int  P_MAX_BURST = DEF_MAX_BURST,
  localparam int L_ID_W      = id_width(P_NUM_REQ),
  localparam int L_CNT_W     = cnt_width(P_MAX_BURST),
  localparam int L_DW        = P_DATA_MSB + 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [P_NUM_REQ-1:0]       i_req_valid,
  input  logic [P_NUM_REQ-1:0]       i_req_last,
  input  logic [P_NUM_REQ*L_DW-1:0]  i_req_data,
  output logic [P_NUM_REQ-1:0]       o_req_ready,
  input  logic                       i_fifo_full,
  output logic                       o_fifo_inc,
  output logic [L_ID_W+L_DW-1:0]     o_fifo_data,
  output logic [L_ID_W-1:0]          o_grant_id,
  output logic                       o_busy
);

  arb_state_e           state_q, state_d;
  logic [L_ID_W-1:0]    grant_q, grant_d;
  logic [L_ID_W-1:0]    rr_last_q, rr_last_d;
  logic [L_CNT_W-1:0]   cnt_q, cnt_d;
  logic [L_CNT_W-1:0]   cnt_inc;
  logic                 any_valid;
  logic [L_ID_W-1:0]    pick_id;
  logic                 xfer;
  logic [P_NUM_REQ-1:0] ready;

  rr_pick #(
    .P_N    (P_NUM_REQ),
    .P_ID_W (L_ID_W)
  ) u_rr_pick (
    .i_req       (i_req_valid),
    .i_rr_last   (rr_last_q),
    .o_any_valid (any_valid),
    .o_pick_id   (pick_id)
  );

  assign cnt_inc = cnt_q + L_CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    ready     = '0;
    xfer      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          grant_d = pick_id;
          cnt_d   = '0;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        ready[grant_q] = !i_fifo_full;
        xfer           = i_req_valid[grant_q] & !i_fifo_full;
        if (xfer) begin
          cnt_d = cnt_inc;
          // Release on end of packet or when the burst cap is hit mid-packet.
          if (i_req_last[grant_q] || (cnt_inc == L_CNT_W'(P_MAX_BURST))) begin
            rr_last_d = grant_q;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_last_q <= L_ID_W'(P_NUM_REQ - 1);
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_req_ready = ready;
  assign o_fifo_inc  = xfer;
  assign o_fifo_data = {grant_q, i_req_data[int'(grant_q)*L_DW +: L_DW]};
  assign o_grant_id  = grant_q;
  assign o_busy      = (state_q == ST_LOCK);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench: per-requester beat streams feed a scoreboard; a negedge monitor checks a cycle reference model.
module tb_fifo_wr_arbiter;

  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int MAXB   = 16;
  localparam int IDW    = 2;
  localparam int BUDGET = 3000;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_last;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              fifo_full;
  logic              fifo_inc;
  logic [IDW+DW-1:0] fifo_data;
  logic [IDW-1:0]    grant_id;
  logic              busy;

  fifo_wr_arbiter #(
    .P_NUM_REQ   (N),
    .P_DATA_MSB  (DW - 1),
    .P_MAX_BURST (MAXB)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_last  (req_last),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .i_fifo_full (fifo_full),
    .o_fifo_inc  (fifo_inc),
    .o_fifo_data (fifo_data),
    .o_grant_id  (grant_id),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] s_dat [N][$];
  bit            s_last[N][$];
  logic [DW-1:0] exp_q [N][$];
  int            ptr   [N];

  // Reference model: owner of the write port (-1 = arbitrating), beats in this grant, last released ID.
  int owner = -1;
  int burst = 0;
  int rr    = N - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0]  exp_rdy;
    logic          exp_inc;
    int            id;
    logic [DW-1:0] d;
    if (!rst_n) begin
      check("rst_busy", 32'(busy), 0);
      check("rst_inc", 32'(fifo_inc), 0);
      check("rst_ready", 32'(req_ready), 0);
      owner = -1;
      burst = 0;
      rr    = N - 1;
    end else begin
      exp_rdy = '0;
      exp_inc = 1'b0;
      if (owner >= 0) begin
        exp_rdy[owner] = !fifo_full;
        exp_inc        = req_valid[owner] && !fifo_full;
      end
      check("busy", 32'(busy), 32'(owner >= 0));
      if (owner >= 0) check("grant_id", 32'(grant_id), 32'(owner));
      check("ready", 32'(req_ready), 32'(exp_rdy));
      check("fifo_inc", 32'(fifo_inc), 32'(exp_inc));
      if (fifo_inc) begin
        id = int'(fifo_data[IDW+DW-1:DW]);
        d  = fifo_data[DW-1:0];
        check("wr_id", 32'(id), 32'(owner));
        if (exp_q[id].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_extra id=%0d act=%0h exp=none t=%0t", id, d, $time);
        end else begin
          check("wr_data", 32'(d), 32'(exp_q[id].pop_front()));
        end
      end
      if (owner < 0) begin
        for (int off = 1; off <= N; off++) begin
          if (owner < 0 && req_valid[(rr + off) % N]) begin
            owner = (rr + off) % N;
            burst = 0;
          end
        end
      end else if (exp_inc) begin
        burst++;
        if (req_last[owner] || burst == MAXB) begin
          rr    = owner;
          owner = -1;
        end
      end
    end
  end

  function automatic bit all_done();
    for (int k = 0; k < N; k++) begin
      if (ptr[k] < s_dat[k].size() || exp_q[k].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drive(input int p_valid, input int p_full);
    for (int k = 0; k < N; k++) begin
      if (ptr[k] < s_dat[k].size()) begin
        req_valid[k]          = ($urandom_range(99) < p_valid);
        req_last[k]           = s_last[k][ptr[k]];
        req_data[k*DW +: DW]  = s_dat[k][ptr[k]];
      end else begin
        req_valid[k]          = 1'b0;
        req_last[k]           = 1'b0;
        req_data[k*DW +: DW]  = '0;
      end
    end
    fifo_full = ($urandom_range(99) < p_full);
  endtask

  task automatic run_phase(input int p_valid, input int p_full, input int min_len,
                           input int max_len, input int npkts, input int rst_at);
    logic [N-1:0] hs;
    bit           done;
    int           len;
    logic [DW-1:0] v;
    for (int k = 0; k < N; k++) begin
      s_dat[k].delete();
      s_last[k].delete();
      ptr[k] = 0;
      for (int p = 0; p < npkts; p++) begin
        len = $urandom_range(max_len, min_len);
        for (int b = 0; b < len; b++) begin
          v = DW'($urandom);
          s_dat[k].push_back(v);
          s_last[k].push_back(b == len - 1);
          exp_q[k].push_back(v);
        end
      end
    end
    drive(p_valid, p_full);
    done = 1'b0;
    for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
      @(negedge clk);
      hs = req_ready & req_valid;
      if (all_done()) begin
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) if (hs[k]) ptr[k]++;
        drive(p_valid, p_full);
        if (cyc == rst_at) begin
          rst_n = 1'b0;
          #1;
          check("async_rst_busy", 32'(busy), 0);
          check("async_rst_inc", 32'(fifo_inc), 0);
          check("async_rst_ready", 32'(req_ready), 0);
        end else begin
          rst_n = 1'b1;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL phase_timeout act=pending exp=drained t=%0t", $time);
    end
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    req_valid = '1;
    req_last  = '0;
    req_data  = '0;
    for (int k = 0; k < N; k++) ptr[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    rst_n     = 1'b1;
    run_phase(100, 0, 2, 2, 2, -1);
    run_phase(70, 20, 1, 6, 6, -1);
    run_phase(90, 10, 20, 20, 2, -1);
    run_phase(60, 50, 1, 8, 5, 30);
    run_phase(85, 30, 10, 24, 3, 45);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
